wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

- Shares the single register-file write port between two sources:
  - the in-order pipeline's WB stage (outputs of the MEM/WB pipeline register);
  - an out-of-band long-latency unit (iterative divider / late load) with a valid/ready handshake.
- The pipeline always has priority. A late result waits in a one-entry holding buffer.
- If the pipeline keeps the port busy for STARVE_LIMIT cycles, the block freezes the pipeline for one cycle to drain the buffer.
- Sits between the MEM/WB register and the register file, next to the hazard/forwarding unit.

## Interface
- XLEN, 32, data width.
- STARVE_LIMIT, 4, consecutive blocked cycles in HOLD before forcing a drain; legal range 1..15.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pipe_we_i  in  1  WB-stage write request, already gated by the bubble flag.
- pipe_rd_i  in  5  WB-stage destination register.
- pipe_data_i  in  XLEN  WB-stage write data.
- lu_valid_i  in  1  long-latency result valid.
- lu_rd_i  in  5  long-latency destination register.
- lu_data_i  in  XLEN  long-latency result.
- lu_ready_o  out  1  block accepts a long-latency result this cycle.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  XLEN  register-file write data.
- stall_o  out  1  freeze IF..MEM/WB this cycle; the MEM/WB register holds its contents.
- hold_valid_o  out  1  holding buffer occupied (for forwarding).
- hold_rd_o  out  5  buffered destination.
- hold_data_o  out  XLEN  buffered data.

## Operation
- States: IDLE (buffer empty), HOLD (buffer full, waiting for a free slot), FORCE (pipeline stalled, buffer drains).
- lu_ready_o = (state==IDLE). A handshake occurs when lu_valid_i && lu_ready_o.
- rd=0 results from either source: never produce rf_we_o=1. A long-latency rd=0 result is accepted and discarded and does not enter HOLD.
- IDLE:
  - Port = pipeline: rf_we_o=pipe_we_i && pipe_rd_i!=0.
  - On handshake with rd!=0: capture rd/data, go to HOLD, cnt←0. Exception: the bypass case under Configuration.
- HOLD with pipe_we_i=1:
  - Pipeline write is granted; cnt←cnt+1.
  - If cnt==STARVE_LIMIT-1, next state is FORCE.
- HOLD with pipe_we_i=0: write the buffer, go to IDLE, cnt←0.
- FORCE:
  - stall_o=1; port drives the buffer contents.
  - The pipeline write present this cycle is not performed. It reappears next cycle because MEM/WB is held.
  - Next state IDLE, cnt←0.
- cnt is 4 bits wide, saturating, and cleared on every exit from HOLD.
- Ordering: the upstream hazard unit guarantees no in-flight pipeline write targets an rd held in the buffer (no WAW). This block does not check it.
- stall_o=1 only in FORCE.
- hold_* outputs reflect the buffer register directly; hold_valid_o=1 in HOLD and FORCE.

## Timing
- Reset values:
  - state=IDLE, cnt=0, buffer cleared.
  - Outputs: lu_ready_o=1, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, stall_o=0, hold_valid_o=0, hold_rd_o=0, hold_data_o=0.
- rf_* outputs and stall_o are combinational from registered state plus pipe_* inputs. No added latency on the pipeline path.
- Long-latency write latency (no bypass): at least 1 cycle after the handshake.
- Worst-case latency: STARVE_LIMIT+1 cycles after the handshake; the FORCE cycle is the last.
- Reset asserted mid-HOLD/FORCE: buffer contents are lost and stall_o drops asynchronously. The pipeline flushes on the same reset.
- Simultaneous pipe_we_i and lu_valid_i in IDLE: pipeline written, long-latency result captured.

## Configuration
- WBARB_BYPASS_EN defined:
  - In IDLE with lu_valid_i=1 and pipe_we_i=0, the result is written to the register file in the same cycle (rf_we_o=1, zero latency).
  - The result is not buffered and the state stays IDLE.
- WBARB_BYPASS_EN undefined: every accepted rd!=0 result goes through HOLD. Minimum latency is 1 cycle.

## Test plan
- Pipeline only: pipe_we_i=1, rd=5, data=0x1234 → rf_we_o=1, waddr=5, wdata=0x1234 same cycle; lu_ready_o stays 1.
- Idle slot, bypass undefined: lu_valid_i, rd=7, data=0xAA, pipe idle → HOLD; next cycle rf_we_o=1, waddr=7; back to IDLE. With WBARB_BYPASS_EN: write in the handshake cycle.
- Starvation, STARVE_LIMIT=4: buffer rd=3, pipe_we_i=1 every cycle → 4 pipeline writes granted, then 1 cycle with stall_o=1 writing rd=3. The held pipe write retires next cycle.
- Collision: pipe_we_i=1 and lu_valid_i=1 in IDLE → pipeline written, hold_valid_o=1, lu_ready_o=0 next cycle.
- rd=0 handling: pipe rd=0 → rf_we_o=0. Long-latency rd=0 → accepted, state remains IDLE, no write.
- Reset during FORCE → stall_o=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order WB stage
// and an out-of-band long-latency unit. The pipeline always wins; a late
// result parks in a one-entry buffer and is written on the next free slot.
// If the pipeline keeps the port busy for STARVE_LIMIT consecutive cycles
// while the buffer is full, the pipeline is frozen for one cycle to drain it.
//
// Optional feature macro: WBARB_BYPASS_EN
//   defined   -> a long-latency result arriving on an idle port is written
//                in the same cycle without being buffered.
//   undefined -> every accepted rd!=0 result goes through the buffer.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4   // legal range 1..15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_data_i,
  input  logic            lu_valid_i,
  input  logic [4:0]      lu_rd_i,
  input  logic [XLEN-1:0] lu_data_i,
  output logic            lu_ready_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            stall_o,
  output logic            hold_valid_o,
  output logic [4:0]      hold_rd_o,
  output logic [XLEN-1:0] hold_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  // Blocked-cycle count at which the next HOLD cycle becomes FORCE.
  localparam logic [3:0] LIM_M1 = 4'(STARVE_LIMIT - 1);

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic [4:0]      buf_rd;
  logic [XLEN-1:0] buf_data;
  logic            capture;

  logic pipe_wr;  // pipeline has a real (rd!=0) write
  logic lu_wr;    // long-latency unit offers a real (rd!=0) result

  assign pipe_wr = pipe_we_i  && (pipe_rd_i != 5'd0);
  assign lu_wr   = lu_valid_i && (lu_rd_i   != 5'd0);

  // State, starvation counter and holding buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      buf_rd   <= 5'd0;
      buf_data <= '0;
    end else begin
      state <= state_nxt;
      // Counter runs only while staying in HOLD; any entry/exit clears it.
      if (state == HOLD && state_nxt == HOLD) begin
        if (cnt != 4'hF) cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
      if (capture) begin
        buf_rd   <= lu_rd_i;
        buf_data <= lu_data_i;
      end
    end
  end

  // Next-state logic and buffer capture decision.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // rd=0 results are handshaken but dropped here.
        if (lu_wr) begin
`ifdef WBARB_BYPASS_EN
          // Free port: result goes straight to the register file.
          if (pipe_we_i) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
`else
          capture   = 1'b1;
          state_nxt = HOLD;
`endif
        end
      end
      HOLD: begin
        if (pipe_we_i) begin
          if (cnt == LIM_M1) state_nxt = FORCE;
        end else begin
          state_nxt = IDLE;
        end
      end
      FORCE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Port mux, stall and handshake outputs; address/data read zero when idle.
  always_comb begin
    rf_we_o      = 1'b0;
    rf_waddr_o   = 5'd0;
    rf_wdata_o   = '0;
    stall_o      = 1'b0;
    lu_ready_o   = (state == IDLE);
    hold_valid_o = (state == HOLD) || (state == FORCE);
    hold_rd_o    = buf_rd;
    hold_data_o  = buf_data;
    case (state)
      IDLE: begin
        if (pipe_wr) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = pipe_rd_i;
          rf_wdata_o = pipe_data_i;
        end
`ifdef WBARB_BYPASS_EN
        else if (!pipe_we_i && lu_wr) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = lu_rd_i;
          rf_wdata_o = lu_data_i;
        end
`endif
      end
      HOLD: begin
        if (pipe_we_i) begin
          if (pipe_wr) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = pipe_rd_i;
            rf_wdata_o = pipe_data_i;
          end
        end else begin
          rf_we_o    = 1'b1;
          rf_waddr_o = buf_rd;
          rf_wdata_o = buf_data;
        end
      end
      FORCE: begin
        // MEM/WB is frozen, so the suppressed pipe write retries next cycle.
        stall_o    = 1'b1;
        rf_we_o    = 1'b1;
        rf_waddr_o = buf_rd;
        rf_wdata_o = buf_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (XLEN=32, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o, rf_we_o, stall_o, hold_valid_o;
  logic [4:0]  rf_waddr_o, hold_rd_o;
  logic [31:0] rf_wdata_o, hold_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
    .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
    .lu_ready_o(lu_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .stall_o(stall_o),
    .hold_valid_o(hold_valid_o), .hold_rd_o(hold_rd_o), .hold_data_o(hold_data_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    pipe_we_i = pwe; pipe_rd_i = prd; pipe_data_i = pd;
    lu_valid_i = lv; lu_rd_i = lrd; lu_data_i = ld;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    n_checks++;
    if ({lu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_o} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_port: got ready=%b we=%b addr=%0d data=%h stall=%b, want 1 0 0 0 0",
               lu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_o);
    end
    n_checks++;
    if ({hold_valid_o, hold_rd_o, hold_data_o} !== {1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%b rd=%0d data=%h, want 0 0 0", hold_valid_o, hold_rd_o, hold_data_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pipe_only();
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, lu_ready_o} !== {1'b1, 5'd5, 32'h1234, 1'b1}) begin
      n_fail++;
      $display("FAIL pipe_only: got we=%b addr=%0d data=%h ready=%b, want 1 5 1234 1",
               rf_we_o, rf_waddr_o, rf_wdata_o, lu_ready_o);
    end
    tick();
    n_checks++;
    if ({lu_ready_o, hold_valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL pipe_only_after: got ready=%b hv=%b, want 1 0", lu_ready_o, hold_valid_o);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_idle_slot();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
`ifdef WBARB_BYPASS_EN
    n_checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'hAA}) begin
      n_fail++;
      $display("FAIL bypass_write: got we=%b addr=%0d data=%h, want 1 7 aa", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({hold_valid_o, lu_ready_o, rf_we_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL bypass_after: got hv=%b ready=%b we=%b, want 0 1 0", hold_valid_o, lu_ready_o, rf_we_o);
    end
`else
    n_checks++;
    if ({rf_we_o, lu_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_hs: got we=%b ready=%b, want 0 1", rf_we_o, lu_ready_o);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({hold_valid_o, hold_rd_o, hold_data_o, lu_ready_o} !== {1'b1, 5'd7, 32'hAA, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_hold: got hv=%b rd=%0d data=%h ready=%b, want 1 7 aa 0",
               hold_valid_o, hold_rd_o, hold_data_o, lu_ready_o);
    end
    n_checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, stall_o} !== {1'b1, 5'd7, 32'hAA, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_drain: got we=%b addr=%0d data=%h stall=%b, want 1 7 aa 0",
               rf_we_o, rf_waddr_o, rf_wdata_o, stall_o);
    end
    tick();
    n_checks++;
    if ({hold_valid_o, lu_ready_o, rf_we_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL idle_back: got hv=%b ready=%b we=%b, want 0 1 0", hold_valid_o, lu_ready_o, rf_we_o);
    end
`endif
  endtask

  // Collision in IDLE followed by continuous pipe writes until FORCE drains.
  task automatic test_collision_starve();
    drive(1'b1, 5'd9, 32'h90, 1'b1, 5'd3, 32'h33);
    n_checks++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h90}) begin
      n_fail++;
      $display("FAIL collide_pipe: got we=%b addr=%0d data=%h, want 1 9 90", rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 32'(16'hB00 + i), 1'b0, 5'd0, 32'd0);
      n_checks++;
      if ({rf_we_o, rf_waddr_o, rf_wdata_o, stall_o, hold_valid_o, lu_ready_o} !==
          {1'b1, 5'(10 + i), 32'(16'hB00 + i), 1'b0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL starve_grant%0d: got we=%b addr=%0d data=%h stall=%b hv=%b ready=%b, want 1 %0d %h 0 1 0",
                 i, rf_we_o, rf_waddr_o, rf_wdata_o, stall_o, hold_valid_o, lu_ready_o, 10 + i, 16'hB00 + i);
      end
      tick();
    end
    drive(1'b1, 5'd14, 32'hE0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, hold_valid_o} !== {1'b1, 1'b1, 5'd3, 32'h33, 1'b1}) begin
      n_fail++;
      $display("FAIL force_drain: got stall=%b we=%b addr=%0d data=%h hv=%b, want 1 1 3 33 1",
               stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, hold_valid_o);
    end
    tick();
    n_checks++;
    if ({stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, hold_valid_o, lu_ready_o} !=
        {1'b0, 1'b1, 5'd14, 32'hE0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL force_retire: got stall=%b we=%b addr=%0d data=%h hv=%b ready=%b, want 0 1 14 e0 0 1",
               stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, hold_valid_o, lu_ready_o);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_rd0();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (rf_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pipe_rd0: got we=%b, want 0", rf_we_o);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
    n_checks++;
    if ({rf_we_o, lu_ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL lu_rd0: got we=%b ready=%b, want 0 1", rf_we_o, lu_ready_o);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({hold_valid_o, lu_ready_o, rf_we_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL lu_rd0_after: got hv=%b ready=%b we=%b, want 0 1 0", hold_valid_o, lu_ready_o, rf_we_o);
    end
  endtask

  task automatic test_reset_in_force();
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0);
      tick();
    end
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_force: got stall=%b, want 1", stall_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    pipe_we_i = 1'b0; pipe_rd_i = 5'd0; pipe_data_i = 32'd0;
    #1;
    n_checks++;
    if ({stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, lu_ready_o} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_rst_port: got stall=%b we=%b addr=%0d data=%h ready=%b, want 0 0 0 0 1",
               stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, lu_ready_o);
    end
    n_checks++;
    if ({hold_valid_o, hold_rd_o, hold_data_o} !== {1'b0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL async_rst_hold: got hv=%b rd=%0d data=%h, want 0 0 0", hold_valid_o, hold_rd_o, hold_data_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    test_reset();
    test_pipe_only();
    test_idle_slot();
    test_collision_starve();
    test_rd0();
    test_reset_in_force();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
